// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of {Instruction, PC+4} between instruction fetch and decode.
// Latency: an entry enqueued on edge N reaches the head after edge N; no input-to-output bypass.
// Backpressure: PCWriteEnable drops while full to hold the PC; DecodeReady pops the head when valid.
// Optional build macro FETCH_QUEUE_NOP_SQUASH_EN: all-zero instructions are never enqueued.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [31:0]              PC,
  input  logic [31:0]              Instruction,
  input  logic                     FetchValid,
  input  logic                     Flush,
  input  logic                     DecodeReady,
  output logic                     PCWriteEnable,
  output logic                     IF_Valid,
  output logic [31:0]              IF_Instruction,
  output logic [31:0]              IF_PCPlus4,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          squash;
  logic          enq;
  logic          deq;

  // Full/empty come from the registered count only, so PCWriteEnable has no
  // combinational path from FetchValid, DecodeReady or Flush.
  assign full  = (Count == FULL_CNT);
  assign empty = (Count == '0);

`ifdef FETCH_QUEUE_NOP_SQUASH_EN
  assign squash = (Instruction == 32'h0000_0000);
`else
  assign squash = 1'b0;
`endif

  // A full queue refuses new fetches even when the head leaves this cycle;
  // the fetch is simply replayed once PCWriteEnable rises again.
  assign enq = FetchValid & ~full & ~Flush & ~squash;
  assign deq = ~empty & DecodeReady & ~Flush;

  // Pointer and occupancy state; flush returns everything to the origin.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      Count  <= '0;
    end else if (Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      Count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  // Entry storage; contents are don't-care once the pointers are cleared.
  always_ff @(posedge Clock) begin
    if (enq) begin
      mem[wr_ptr] <= '{instr: Instruction, pc_plus4: PC + 32'd4};
    end
  end

  assign head           = mem[rd_ptr];
  assign IF_Valid       = ~empty;
  assign IF_Instruction = empty ? 32'h0 : head.instr;
  assign IF_PCPlus4     = empty ? 32'h0 : head.pc_plus4;
  assign PCWriteEnable  = ~full;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PC = '0;
  logic [31:0] Instruction = '0;
  logic        FetchValid = 1'b0;
  logic        Flush = 1'b0;
  logic        DecodeReady = 1'b0;
  logic        PCWriteEnable;
  logic        IF_Valid;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCPlus4;
  logic [$clog2(DEPTH):0] Count;

  int checks = 0;
  int failures = 0;

  // Expected queue contents, oldest first: {instruction, pc+4}.
  logic [63:0] sb[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .PC(PC), .Instruction(Instruction),
    .FetchValid(FetchValid), .Flush(Flush), .DecodeReady(DecodeReady),
    .PCWriteEnable(PCWriteEnable), .IF_Valid(IF_Valid),
    .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4), .Count(Count)
  );

  always #5 Clock = ~Clock;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic squashed(input logic [31:0] ins);
`ifdef FETCH_QUEUE_NOP_SQUASH_EN
    return ins == 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  // Called just after a rising edge: apply inputs, predict, step one cycle.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic dr, input logic fl);
    logic will_enq;
    FetchValid = fv; PC = pc; Instruction = ins; DecodeReady = dr; Flush = fl;
    will_enq = fv && !fl && (sb.size() < DEPTH) && !squashed(ins);
    @(posedge Clock);
    if (fl) sb.delete();
    else if (will_enq) sb.push_back({ins, pc + 32'd4});
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: on every falling edge compare visible state with the model and
  // retire the head when decode takes it on the coming edge.
  initial begin
    forever begin
      @(negedge Clock);
      check("count", 64'(Count), 64'(sb.size()));
      check("pcwe", 64'(PCWriteEnable), 64'(sb.size() < DEPTH));
      check("valid", 64'(IF_Valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("head", {IF_Instruction, IF_PCPlus4}, sb[0]);
        if (DecodeReady && !Flush && !Reset) void'(sb.pop_front());
      end else begin
        check("empty_out", {IF_Instruction, IF_PCPlus4}, 64'h0);
      end
    end
  end

  initial begin
    #2;
    check("rst_count", 64'(Count), 64'h0);
    check("rst_pcwe", 64'(PCWriteEnable), 64'h1);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    // Fill to full with decode stalled.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b0, 1'b0);
    check("fill_count", 64'(Count), 64'd4);
    check("fill_pcwe", 64'(PCWriteEnable), 64'h0);
    check("fill_head", {IF_Instruction, IF_PCPlus4}, {32'h1111_1111, 32'h4});

    // Fetch offered while full with a dequeue: dequeue only.
    drive(1'b1, 32'h10, 32'h5555_5555, 1'b1, 1'b0);
    check("full_deq_count", 64'(Count), 64'd3);
    check("full_deq_pcwe", 64'(PCWriteEnable), 64'h1);
    check("full_deq_head", {IF_Instruction, IF_PCPlus4}, {32'h2222_2222, 32'h8});

    // Down to two, then six simultaneous enq/deq cycles crossing the wrap.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    check("steady_count", 64'(Count), 64'd2);
    check("steady_head", {IF_Instruction, IF_PCPlus4}, {32'hA000_0004, 32'h114});

    // Flush wins over a same-cycle enqueue and dequeue.
    drive(1'b1, 32'h200, 32'hB000_0000, 1'b0, 1'b0);
    check("pre_flush_count", 64'(Count), 64'd3);
    drive(1'b1, 32'h204, 32'hB000_0001, 1'b1, 1'b1);
    check("flush_count", 64'(Count), 64'd0);
    check("flush_valid", 64'(IF_Valid), 64'h0);
    check("flush_out", {IF_Instruction, IF_PCPlus4}, 64'h0);

    // PC+4 wraps to zero.
    drive(1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("wrap_pc4", 64'(IF_PCPlus4), 64'h0);

    // Asynchronous reset between edges with three entries queued.
    drive(1'b1, 32'h300, 32'hC000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h304, 32'hC000_0001, 1'b0, 1'b0);
    FetchValid = 1'b0; DecodeReady = 1'b0;
    #2 Reset = 1'b1;
    sb.delete();
    #1;
    check("async_rst_count", 64'(Count), 64'h0);
    check("async_rst_out", {IF_Instruction, IF_PCPlus4}, 64'h0);
    check("async_rst_pcwe", 64'(PCWriteEnable), 64'h1);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // All-zero instruction: squashed only when the option is built in.
    drive(1'b1, 32'h400, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_QUEUE_NOP_SQUASH_EN
    check("nop_count", 64'(Count), 64'd0);
`else
    check("nop_count", 64'(Count), 64'd1);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("after_nop_count", 64'(Count), 64'd0);

    // Randomised traffic checked by the monitor against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc, ins;
      pc  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : $urandom;
      ins = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 99) == 0) begin
        FetchValid = 1'b0; DecodeReady = 1'b0; Flush = 1'b0;
        #2 Reset = 1'b1;
        sb.delete();
        #1 Reset = 1'b0;
        @(posedge Clock); #1;
      end else begin
        drive($urandom_range(0, 9) < 7, pc, ins, $urandom_range(0, 9) < 5,
              $urandom_range(0, 29) == 0);
      end
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain_count", 64'(Count), 64'd0);

    @(negedge Clock); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
